// File: rtl/exibe_sequencia_pkg.sv
// Shared definitions for the sequence presentation block: state codes and timer sizing.
package exibe_sequencia_pkg;

   // State codes are visible on db_estado, so every value is pinned explicitly.
   typedef enum logic [3:0] {
      StInicial    = 4'd0,
      StPreparacao = 4'd1,
      StBusca      = 4'd2,
      StAcende     = 4'd3,
      StApaga      = 4'd4,
      StProximo    = 4'd5,
      StFim        = 4'd6
   } estado_t;

   // Width of a counter that must reach max(a, b) - 1; never narrower than 1 bit.
   function automatic int unsigned largura_timer(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/sync_rom_16x4.sv
// 16x4 ROM with registered output: data_out reflects the address sampled on the last edge.
module sync_rom_16x4 (
   input  logic       clock,
   input  logic [3:0] address,
   output logic [3:0] data_out
);

   // Registered read of the fixed game sequence.
   always_ff @(posedge clock) begin
      case (address)
         4'h0:    data_out <= 4'h1;
         4'h1:    data_out <= 4'h0;
         4'h2:    data_out <= 4'h4;
         4'h3:    data_out <= 4'h8;
         4'h4:    data_out <= 4'h3;
         4'h5:    data_out <= 4'h6;
         4'h6:    data_out <= 4'hc;
         4'h7:    data_out <= 4'h9;
         4'h8:    data_out <= 4'h5;
         4'h9:    data_out <= 4'ha;
         4'ha:    data_out <= 4'hf;
         4'hb:    data_out <= 4'h7;
         4'hc:    data_out <= 4'he;
         4'hd:    data_out <= 4'hd;
         4'he:    data_out <= 4'hb;
         default: data_out <= 4'h2;
      endcase
   end

endmodule

// File: rtl/exibe_sequencia.sv
// Plays ROM words 0..limite on the LEDs with timed lit/dark gaps, then pulses pronto.
module exibe_sequencia
   import exibe_sequencia_pkg::*;
#(
   parameter int unsigned TEMPO_LED     = 4,
   parameter int unsigned TEMPO_APAGADO = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [3:0] limite,
   output logic [3:0] leds,
   output logic       exibindo,
   output logic       pronto,
   output logic [3:0] db_endereco,
   output logic [3:0] db_estado
);

   localparam int unsigned TW = largura_timer(TEMPO_LED, TEMPO_APAGADO);
   localparam logic [TW-1:0] FIM_LED     = TW'(TEMPO_LED - 1);
   localparam logic [TW-1:0] FIM_APAGADO = TW'(TEMPO_APAGADO - 1);

   estado_t       estado_q, estado_d;
   logic [3:0]    endereco_q, endereco_d;
   logic [3:0]    limite_q, limite_d;
   logic [3:0]    dado_q, dado_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    rom_out;

   // The ROM is addressed with the next address so its registered output is already
   // valid for that address by the time busca ends and dado is captured.
   sync_rom_16x4 u_rom (
      .clock    (clock),
      .address  (endereco_d),
      .data_out (rom_out)
   );

   // State and datapath registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q   <= StInicial;
         endereco_q <= 4'd0;
         limite_q   <= 4'd0;
         dado_q     <= 4'd0;
         timer_q    <= '0;
      end else begin
         estado_q   <= estado_d;
         endereco_q <= endereco_d;
         limite_q   <= limite_d;
         dado_q     <= dado_d;
         timer_q    <= timer_d;
      end
   end

   // Next state and datapath updates.
   always_comb begin
      estado_d   = estado_q;
      endereco_d = endereco_q;
      limite_d   = limite_q;
      dado_d     = dado_q;
      timer_d    = timer_q;
      case (estado_q)
         StInicial: begin
            if (iniciar) begin
               limite_d = limite;
               estado_d = StPreparacao;
            end
         end
         StPreparacao: begin
            endereco_d = 4'd0;
            timer_d    = '0;
            estado_d   = StBusca;
         end
         StBusca: begin
            dado_d   = rom_out;
            estado_d = StAcende;
         end
         StAcende: begin
            if (timer_q == FIM_LED) begin
               timer_d  = '0;
               estado_d = StApaga;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         StApaga: begin
            if (timer_q == FIM_APAGADO) begin
               timer_d  = '0;
               estado_d = (endereco_q == limite_q) ? StFim : StProximo;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         StProximo: begin
            // Only reached when endereco < limite, so this never wraps past 15.
            endereco_d = endereco_q + 4'd1;
            estado_d   = StBusca;
         end
         StFim: begin
            estado_d = StInicial;
         end
         default: begin
            estado_d = StInicial;
         end
      endcase
   end

   // Outputs decoded from registers only.
   always_comb begin
      leds        = (estado_q == StAcende) ? dado_q : 4'd0;
      exibindo    = (estado_q != StInicial) && (estado_q != StFim);
      pronto      = (estado_q == StFim);
      db_endereco = endereco_q;
      db_estado   = estado_q;
   end

endmodule
